// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter between the CPU MEM stage and a DMA/debug requester.
// Sub-word CPU stores are sequenced as word read-modify-write.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   cpu_req/we/addr/...   CPU access; cpu_stall holds it, cpu_rdata returns loads
//   dma_req/we/addr/...   DMA word access; dma_gnt completes it, dma_rdata returns reads
//   mem_*                 the single memory port; mem_ready completes an access
module dmem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int DMA_MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic [1:0]    cpu_mask,
    input  logic          cpu_sext,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_valid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    output logic [1:0]    mem_mask,
    output logic          mem_sext,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    typedef enum logic [2:0] {
        IDLE,
        CPU_ACC,
        RMW_RD,
        RMW_WR,
        DMA_ACC
    } state_t;

    localparam int CW = $clog2(DMA_MAX_WAIT + 1);

    state_t        state;
    state_t        cur;
    state_t        nxt;
    logic [CW-1:0] wait_cnt;
    logic [DW-1:0] old_word;
    logic [DW-1:0] merged;
    logic          sub_store;
    logic          dma_turn;
    logic [AW-1:0] cpu_waddr;
    logic [AW-1:0] dma_waddr;
    logic          unused_bits;

    assign unused_bits = ^dma_addr[1:0];

    assign sub_store = cpu_we & ~cpu_mask[1];
    assign dma_turn  = dma_req & (wait_cnt >= CW'(DMA_MAX_WAIT));
    assign cpu_waddr = {cpu_addr[AW-1:2], 2'b00};
    assign dma_waddr = {dma_addr[AW-1:2], 2'b00};

    // Effective state: from IDLE the winner is issued in the same cycle.
    always_comb begin
        cur = state;
        if (reset) begin
            cur = IDLE;
        end else if (state == IDLE) begin
            if (dma_turn)
                cur = DMA_ACC;
            else if (cpu_req)
                cur = sub_store ? RMW_RD : CPU_ACC;
            else if (dma_req)
                cur = DMA_ACC;
        end
    end

    always_comb begin
        nxt = cur;
        if (mem_ready) begin
            unique case (cur)
                CPU_ACC: nxt = IDLE;
                RMW_RD:  nxt = RMW_WR;
                RMW_WR:  nxt = IDLE;
                DMA_ACC: nxt = IDLE;
                default: nxt = cur;
            endcase
        end
    end

    // Half stores pick the lane pair by addr[1]; addr[0] is ignored.
    always_comb begin
        merged = old_word;
        if (cpu_mask == 2'd0)
            merged[{cpu_addr[1:0], 3'b000} +: 8] = cpu_wdata[7:0];
        else
            merged[{cpu_addr[1], 4'b0000} +: 16] = cpu_wdata[15:0];
    end

    always_comb begin
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_mask  = 2'd2;
        mem_sext  = 1'b0;
        cpu_rdata = '0;
        dma_gnt   = 1'b0;
        dma_rdata = '0;
        unique case (cur)
            CPU_ACC: begin
                mem_valid = 1'b1;
                mem_addr  = cpu_addr;
                mem_we    = cpu_we;
                mem_wdata = cpu_wdata;
                mem_mask  = (cpu_mask == 2'd3) ? 2'd2 : cpu_mask;
                mem_sext  = cpu_sext;
                if (mem_ready)
                    cpu_rdata = mem_rdata;
            end
            RMW_RD: begin
                mem_valid = 1'b1;
                mem_addr  = cpu_waddr;
            end
            RMW_WR: begin
                mem_valid = 1'b1;
                mem_addr  = cpu_waddr;
                mem_we    = 1'b1;
                mem_wdata = merged;
            end
            DMA_ACC: begin
                mem_valid = 1'b1;
                mem_addr  = dma_waddr;
                mem_we    = dma_we;
                mem_wdata = dma_wdata;
                if (mem_ready) begin
                    dma_gnt   = 1'b1;
                    dma_rdata = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    assign cpu_stall = cpu_req & ~reset &
                       ~(((cur == CPU_ACC) | (cur == RMW_WR)) & mem_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            old_word <= '0;
        end else begin
            state <= nxt;
            if (cur == RMW_RD && mem_ready)
                old_word <= mem_rdata;
            if (!dma_req || dma_gnt)
                wait_cnt <= '0;
            else if (wait_cnt != CW'(DMA_MAX_WAIT))
                wait_cnt <= wait_cnt + CW'(1);
        end
    end

endmodule
